// File: rtl/measure_builder.sv
// Converts note/rest events into eighth-note score events, tracks bar position and queues them in a show-ahead FIFO.
// Optional MEASURE_SPLIT_EN: split bar-crossing events into tied head/tail pieces.
module measure_builder #(
  parameter int MEASURE_EIGHTHS = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          new_note_ready,
  input  logic [5:0]                    new_note_tone,
  input  logic                          eighth_note,
  input  logic                          quarter_note,
  input  logic                          half_note,
  input  logic                          whole_note,
  input  logic                          eighth_rest,
  input  logic                          quarter_rest,
  input  logic                          half_rest,
  input  logic                          whole_rest,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [5:0]                    ev_tone,
  output logic [3:0]                    ev_dur,
  output logic                          ev_rest,
  output logic                          ev_tie,
  output logic                          ev_bar_end,
  output logic [15:0]                   measure_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] MEAS = 5'(MEASURE_EIGHTHS);

`ifdef MEASURE_SPLIT_EN
  typedef enum logic [1:0] {IDLE, HEAD, TAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEAD} state_t;
`endif

  // FIFO entry: {tone, dur, rest, tie, bar_end}
  typedef logic [12:0] entry_t;

  state_t        state_q, state_d;
  logic          nr_prev_q;
  logic [5:0]    tone_q, tone_d;
  logic [3:0]    dur_q, dur_d;
  logic          rest_q, rest_d;
  logic [4:0]    pos_q, pos_d;
  logic [15:0]   mc_q, mc_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
`ifdef MEASURE_SPLIT_EN
  logic [4:0]    tail_q, tail_d;
  logic [4:0]    room;
`endif

  logic       capture, cap_valid;
  logic [3:0] dec_dur;
  logic       dec_rest;
  logic [4:0] dur5, sum;
  logic       push, pop, push_ok;
  logic [3:0] wr_dur;
  logic       wr_tie, wr_bar;
  entry_t     head;

  // Longest flag wins; a rest flag at the winning length marks a rest.
  always_comb begin
    dec_dur  = 4'd0;
    dec_rest = 1'b0;
    if (whole_note || whole_rest) begin
      dec_dur  = 4'd8;
      dec_rest = whole_rest;
    end else if (half_note || half_rest) begin
      dec_dur  = 4'd4;
      dec_rest = half_rest;
    end else if (quarter_note || quarter_rest) begin
      dec_dur  = 4'd2;
      dec_rest = quarter_rest;
    end else if (eighth_note || eighth_rest) begin
      dec_dur  = 4'd1;
      dec_rest = eighth_rest;
    end
  end

  assign capture   = new_note_ready && !nr_prev_q;
  assign cap_valid = capture && (dec_dur != 4'd0);
  assign dur5      = {1'b0, dur_q};
  assign sum       = pos_q + dur5;
`ifdef MEASURE_SPLIT_EN
  assign room      = MEAS - pos_q;
`endif

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    rest_d  = rest_q;
    pos_d   = pos_q;
    mc_d    = mc_q;
    push    = 1'b0;
    wr_dur  = 4'd0;
    wr_tie  = 1'b0;
    wr_bar  = 1'b0;
`ifdef MEASURE_SPLIT_EN
    tail_d  = tail_q;
`endif
    case (state_q)
      IDLE: begin
        if (cap_valid) begin
          tone_d  = new_note_tone;
          dur_d   = dec_dur;
          rest_d  = dec_rest || (new_note_tone == 6'd0);
          state_d = HEAD;
        end
      end
      HEAD: begin
        push    = 1'b1;
        state_d = IDLE;
`ifdef MEASURE_SPLIT_EN
        if (dur5 < room) begin
          wr_dur = dur_q;
          pos_d  = sum;
        end else if (dur5 == room) begin
          wr_dur = dur_q;
          wr_bar = 1'b1;
          pos_d  = 5'd0;
          mc_d   = mc_q + 16'd1;
        end else begin
          wr_dur  = room[3:0];
          wr_tie  = !rest_q;
          wr_bar  = 1'b1;
          pos_d   = 5'd0;
          mc_d    = mc_q + 16'd1;
          tail_d  = dur5 - room;
          state_d = TAIL;
        end
`else
        wr_dur = dur_q;
        if (sum >= MEAS) begin
          wr_bar = 1'b1;
          pos_d  = sum - MEAS;
          mc_d   = mc_q + 16'd1;
        end else begin
          pos_d  = sum;
        end
`endif
      end
`ifdef MEASURE_SPLIT_EN
      TAIL: begin
        push    = 1'b1;
        wr_dur  = tail_q[3:0];
        pos_d   = tail_q;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Show-ahead FIFO; a full FIFO still accepts a push when the head pops the same cycle.
  assign ev_valid = (count_q != '0);
  assign pop      = ev_valid && ev_ready;
  assign push_ok  = push && ((count_q < CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {tone_q, wr_dur, rest_q, wr_tie, wr_bar};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    if ((push && !push_ok) || (cap_valid && state_q != IDLE)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      nr_prev_q <= 1'b1;
      tone_q    <= '0;
      dur_q     <= '0;
      rest_q    <= 1'b0;
      pos_q     <= '0;
      mc_q      <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_q     <= '{default: '0};
`ifdef MEASURE_SPLIT_EN
      tail_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      nr_prev_q <= new_note_ready;
      tone_q    <= tone_d;
      dur_q     <= dur_d;
      rest_q    <= rest_d;
      pos_q     <= pos_d;
      mc_q      <= mc_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
`ifdef MEASURE_SPLIT_EN
      tail_q    <= tail_d;
`endif
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign ev_tone       = head[12:7];
  assign ev_dur        = head[6:3];
  assign ev_rest       = head[2];
  assign ev_tie        = head[1];
  assign ev_bar_end    = head[0];
  assign measure_count = mc_q;
  assign fifo_count    = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_measure_builder.sv
// Directed bench for measure_builder; expectations follow MEASURE_SPLIT_EN when it is defined.
module tb_measure_builder;

  localparam logic [7:0] F_E = 8'h01, F_Q = 8'h02, F_W = 8'h08, R_H = 8'h40;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        new_note_ready = 1'b0;
  logic [5:0]  new_note_tone = '0;
  logic [7:0]  flags = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid, ev_rest, ev_tie, ev_bar_end, overflow;
  logic [5:0]  ev_tone;
  logic [3:0]  ev_dur;
  logic [15:0] measure_count;
  logic [4:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  measure_builder #(.MEASURE_EIGHTHS(8), .FIFO_DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .new_note_ready(new_note_ready), .new_note_tone(new_note_tone),
    .eighth_note(flags[0]), .quarter_note(flags[1]), .half_note(flags[2]), .whole_note(flags[3]),
    .eighth_rest(flags[4]), .quarter_rest(flags[5]), .half_rest(flags[6]), .whole_rest(flags[7]),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_tone(ev_tone), .ev_dur(ev_dur),
    .ev_rest(ev_rest), .ev_tie(ev_tie), .ev_bar_end(ev_bar_end),
    .measure_count(measure_count), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    new_note_ready = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  // Rising edge captured at the first edge, event written at the second.
  task automatic send(input logic [5:0] tone, input logic [7:0] fl);
    new_note_tone = tone;
    flags = fl;
    new_note_ready = 1'b1;
    tick();
    new_note_ready = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    rst_in = 1'b0;
    #12;
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_mc", measure_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dur", ev_dur, 0);
    rst_in = 1'b1;
    tick();

    // Four quarters fill one bar
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(6'd12, F_Q);
      chk("q_valid", ev_valid, 1);
      chk("q_tone", ev_tone, 12);
      chk("q_dur", ev_dur, 2);
      chk("q_bar", ev_bar_end, (i == 3) ? 1 : 0);
    end
    chk("q_mc", measure_count, 1);
    tick();
    send(6'd3, F_W);
    chk("q_pos0_dur", ev_dur, 8);
    chk("q_pos0_bar", ev_bar_end, 1);
    chk("q_pos0_tie", ev_tie, 0);
    tick();

    // Bar crossing from pos 6 with a whole note
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(6'd1, F_Q);
    send(6'd5, F_W);
`ifdef MEASURE_SPLIT_EN
    chk("x_head_dur", ev_dur, 2);
    chk("x_head_tie", ev_tie, 1);
    chk("x_head_bar", ev_bar_end, 1);
    chk("x_mc", measure_count, 1);
    tick();
    chk("x_tail_tone", ev_tone, 5);
    chk("x_tail_dur", ev_dur, 6);
    chk("x_tail_tie", ev_tie, 0);
    chk("x_tail_bar", ev_bar_end, 0);
`else
    chk("x_dur", ev_dur, 8);
    chk("x_tie", ev_tie, 0);
    chk("x_bar", ev_bar_end, 1);
    chk("x_mc", measure_count, 1);
`endif
    tick();
    send(6'd7, F_Q);
    chk("x_pos6_bar", ev_bar_end, 1);
    chk("x_pos6_mc", measure_count, 2);
    tick();

    // Level held high: one event only
    do_reset();
    ev_ready = 1'b0;
    new_note_tone = 6'd0;
    flags = R_H;
    new_note_ready = 1'b1;
    repeat (500) tick();
    new_note_ready = 1'b0;
    tick();
    chk("hold_count", fifo_count, 1);
    chk("hold_tone", ev_tone, 0);
    chk("hold_dur", ev_dur, 4);
    chk("hold_rest", ev_rest, 1);
    chk("hold_tie", ev_tie, 0);

    // Level held across reset release: no event
    rst_in = 1'b0;
    new_note_ready = 1'b1;
    tick();
    rst_in = 1'b1;
    repeat (5) tick();
    chk("hold_rst_count", fifo_count, 0);
    chk("hold_rst_valid", ev_valid, 0);
    new_note_ready = 1'b0;
    tick();

    // 17 eighths into a 16-deep FIFO with no consumer
    do_reset();
    ev_ready = 1'b0;
    for (int i = 1; i <= 17; i++) send(6'(i), F_E);
    chk("fill_count", fifo_count, 16);
    chk("fill_ovf", overflow, 1);
    chk("fill_mc", measure_count, 2);
    ev_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", ev_valid, 1);
      chk("drain_tone", ev_tone, i + 1);
      chk("drain_bar", ev_bar_end, (i == 7 || i == 15) ? 1 : 0);
      tick();
    end
    chk("drain_empty", fifo_count, 0);

    // Full FIFO, push coinciding with a pop
    do_reset();
    ev_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(6'(i), F_E);
    chk("full_count", fifo_count, 16);
    new_note_tone = 6'd20;
    flags = F_E;
    new_note_ready = 1'b1;
    tick();
    new_note_ready = 1'b0;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("pp_count", fifo_count, 16);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", ev_tone, 2);

    // No flags, then two flags at once
    do_reset();
    ev_ready = 1'b1;
    send(6'd9, 8'h00);
    chk("noflag_valid", ev_valid, 0);
    chk("noflag_mc", measure_count, 0);
    send(6'd9, F_Q | F_W);
    chk("multi_dur", ev_dur, 8);
    chk("multi_bar", ev_bar_end, 1);
    tick();

    // Edge arriving right after a splitting capture
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(6'd1, F_Q);
    new_note_tone = 6'd5;
    flags = F_W;
    new_note_ready = 1'b1;
    tick();
    new_note_ready = 1'b0;
    tick();
    new_note_tone = 6'd6;
    flags = F_Q;
    new_note_ready = 1'b1;
    tick();
`ifdef MEASURE_SPLIT_EN
    chk("coll_ovf", overflow, 1);
`else
    chk("coll_ovf", overflow, 0);
`endif
    new_note_ready = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/measure_builder.md
Name: measure_builder

Overview:
- Sits directly downstream of the note duration detector.
- Converts each note/rest event (tone plus one-hot duration flags) into eighth-note units and tracks position within the bar.
- Splits events that cross a bar line into tied head/tail pieces.
- Buffers resulting score events in a show-ahead FIFO with a valid/ready output for the score renderer.

Parameters:
- MEASURE_EIGHTHS, 8, eighth notes per bar (legal range 8..16; 8 = 4/4).
- FIFO_DEPTH, 16, output event FIFO depth; power of two, ≥2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- new_note_ready  input  1  event present; may stay high for many cycles; only a rising edge counts.
- new_note_tone  input  6  note index; 0 = rest.
- eighth_note, quarter_note, half_note, whole_note  input  1 each  duration flags for tones.
- eighth_rest, quarter_rest, half_rest, whole_rest  input  1 each  duration flags for rests.
- ev_valid  output  1  FIFO head valid.
- ev_ready  input  1  consumer accepts head.
- ev_tone  output  6  event tone.
- ev_dur  output  4  duration in eighths (1..8).
- ev_rest  output  1  event is a rest.
- ev_tie  output  1  tied to the following event.
- ev_bar_end  output  1  event ends a bar.
- measure_count  output  16  completed bars; wraps modulo 2^16.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky drop indicator.

Behaviour:
- Reset (rst_in low, asynchronous):
  - all outputs 0; FIFO emptied; pos=0; FSM=IDLE.
  - Edge-detect history register resets to 1, so a level held high across reset release is not taken as an event.
- Event capture: edge k where new_note_ready=1 and previous sample=0.
- Duration decode: whole=8, half=4, quarter=2, eighth=1.
  - Multiple flags set: longest wins.
  - No flag set: edge ignored, no state change.
  - ev_rest=1 if any rest flag won or new_note_tone==0.
- FSM states:
  - IDLE: on a valid capture, latch tone, dur, rest → HEAD.
  - HEAD: compute room = MEASURE_EIGHTHS − pos.
    - dur<room: write (dur, tie=0, bar_end=0); pos+=dur; → IDLE.
    - dur==room: write (dur, bar_end=1); pos=0; measure_count++; → IDLE.
    - dur>room: write (room, tie=!rest, bar_end=1); pos=0; measure_count++; → TAIL.
  - TAIL: write (dur−room, tie=0, bar_end=0); pos=dur−room; → IDLE. Tail is always <MEASURE_EIGHTHS, so it never closes a bar.
- Latency: head written at edge k+1; ev_valid rises after edge k+1 if the FIFO was empty. Tail written at edge k+2.
- Busy collision: a rising edge captured while FSM≠IDLE is dropped and sets overflow.
- FIFO:
  - ev_valid = !empty; ev_* always reflect the head entry; pop when ev_valid && ev_ready.
  - Push accepted if count<FIFO_DEPTH or a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set; pos and measure_count still advance so bar alignment is preserved.
  - Simultaneous push and pop: count unchanged.
- Widths: pos 5 bits; room and tail computed in 5 bits; ev_dur carries the low 4 bits (values ≤8).
- overflow clears only on reset.

Optional Feature:
- Macro: MEASURE_SPLIT_EN.
- Defined: bar-crossing split into head/tail as above, with ties.
- Undefined:
  - TAIL state absent; every event written once with full dur and ev_tie=0.
  - If pos+dur ≥ MEASURE_EIGHTHS: ev_bar_end=1, pos = pos+dur−MEASURE_EIGHTHS, measure_count++.
  - Otherwise pos+=dur.

Test Plan:
- Reset, then four quarter_note rising edges, tone 12, ev_ready=1 → four events (12, dur 2); fourth has bar_end=1; measure_count=1; pos=0.
- pos=6 (three quarters), then whole_note tone 5, split enabled → head (5, dur 2, tie=1, bar_end=1), tail (5, dur 6, tie=0); measure_count=1; final pos=6. Split disabled → single (5, dur 8, bar_end=1); pos=6.
- new_note_ready held high for 500 cycles with half_rest → exactly one event (tone 0, dur 4, rest=1, tie=0); held high across reset release → no event.
- ev_ready=0, FIFO_DEPTH=16, 17 eighth_note edges → fifo_count=16; overflow=1; measure_count=2. Then ev_ready=1 → 16 events drain in order.
- Full FIFO with ev_ready=1 and a simultaneous push → push accepted; fifo_count stays 16; overflow stays 0.
- Rising edge with no flags → no event. Rising edge with quarter_note and whole_note both set → dur 8. Rising edge arriving one cycle after a splitting capture → dropped; overflow=1.
